// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse generator: FSM state encoding and default sizes.
// The optional pending-request queue is enabled by defining PULSE_GEN_PENDING_EN.
package pulse_gen_pkg;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_PEND_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic logic is_active(state_t s);
      return s != IDLE;
   endfunction

endpackage

// File: rtl/pulse_gen_pend_cnt.sv
// Saturating up/down counter of pulse requests waiting behind the one in progress.
// A simultaneous increment and decrement leaves the count unchanged and is never rejected.
module pulse_gen_pend_cnt
   import pulse_gen_pkg::*;
#(
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic nonzero,
   output logic reject
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [PEND_W-1:0] count;
   logic              full;

   assign full    = (count == PEND_MAX);
   assign nonzero = (count != '0);
   assign reject  = inc && !dec && full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + 1'b1;
      end else if (dec && !inc) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse generator: width-cycle pulses followed by a gap-cycle low time.
// Define PULSE_GEN_PENDING_EN to queue requests arriving while busy instead of dropping them.
module pulse_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] gap,
   output logic             pulse_out,
   output logic             busy,
   output logic             drop
);

   if (PEND_W < 1 || CNT_W < 1) begin : g_bad_params
      $error("pulse_gen: CNT_W and PEND_W must be at least 1");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] width_eff;
   logic             cnt_last;
   logic             start;
   logic             pulse_nxt;
   logic             drop_nxt;
   logic             pend_nz;

   assign width_eff = (width == '0) ? CNT_W'(1) : width;
   assign cnt_last  = (cnt == CNT_W'(1));

`ifdef PULSE_GEN_PENDING_EN
   logic pend_inc;
   logic pend_dec;
   logic pend_reject;

   // A trig counts as queued whenever it cannot start a pulse by itself,
   // which includes an idle cycle spent draining a request queued on a final cycle.
   assign pend_inc = trig && (is_active(state) || pend_nz);
   assign pend_dec = start && pend_nz;
   assign drop_nxt = pend_reject;

   pulse_gen_pend_cnt #(
      .PEND_W (PEND_W)
   ) u_pend (
      .clk     (clk),
      .rst     (rst),
      .inc     (pend_inc),
      .dec     (pend_dec),
      .nonzero (pend_nz),
      .reject  (pend_reject)
   );
`else
   assign pend_nz  = 1'b0;
   assign drop_nxt = trig && is_active(state);
`endif

   // Next-state logic; a new pulse always loads the width sampled on its start edge
   // and the gap is only looked at on the final high cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = pulse_out;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (trig || pend_nz) begin
               start = 1'b1;
            end
         end
         HIGH: begin
            if (!cnt_last) begin
               cnt_nxt = cnt - 1'b1;
            end else if (gap != '0) begin
               state_nxt = GAP;
               cnt_nxt   = gap;
               pulse_nxt = 1'b0;
            end else if (pend_nz) begin
               start = 1'b1;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               pulse_nxt = 1'b0;
            end
         end
         GAP: begin
            if (!cnt_last) begin
               cnt_nxt = cnt - 1'b1;
            end else if (pend_nz) begin
               start = 1'b1;
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pulse_nxt = 1'b0;
         end
      endcase
      if (start) begin
         state_nxt = HIGH;
         cnt_nxt   = width_eff;
         pulse_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pulse_out <= 1'b0;
         drop      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pulse_out <= pulse_nxt;
         drop      <= drop_nxt;
      end
   end

   assign busy = is_active(state) || pend_nz;

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
- REQ-001: Parameter CNT_W, default 8, SHALL set the bit width of the width and gap inputs and of the internal down-counter.
- REQ-002: Parameter PEND_W, default 4, SHALL set the width of the pending-request counter; the counter saturates at 2^PEND_W-1.
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  SHALL be the reset: asynchronous, active-high.
- REQ-005: trig  input  1  SHALL be the request strobe; each cycle sampled high is one pulse request (the level produced by an upstream edge detector).
- REQ-006: width  input  CNT_W  SHALL give the high time of a pulse in cycles; sampled when that pulse starts.
- REQ-007: gap  input  CNT_W  SHALL give the minimum low time after a pulse in cycles; sampled when the pulse ends.
- REQ-008: pulse_out  output  1  SHALL be the generated pulse, registered.
- REQ-009: busy  output  1  SHALL be high when state is not IDLE or pending count is nonzero.
- REQ-010: drop  output  1  SHALL be a one-cycle registered strobe flagging a discarded request.

Function
- REQ-011: The FSM SHALL have exactly three states: IDLE, HIGH, GAP.
- REQ-012: IDLE with trig=1 at edge N SHALL go to HIGH, load the counter with max(width,1), and drive pulse_out=1 from the cycle after edge N.
- REQ-013: pulse_out SHALL stay high for exactly max(width,1) cycles; width=0 is treated as 1.
- REQ-014: On the last HIGH cycle: gap!=0 SHALL go to GAP and load the counter with gap; gap=0 SHALL go straight to the next-request check (REQ-016).
- REQ-015: GAP SHALL hold pulse_out=0 for exactly gap cycles.
- REQ-016: At the end of a pulse or gap, a nonzero pending count SHALL decrement it and start a new HIGH on the next cycle with no idle cycle; otherwise the FSM returns to IDLE.
- REQ-017: trig=1 while not IDLE SHALL increment the pending count, including on the final HIGH/GAP cycle.
- REQ-018: trig=1 in the same cycle the pending count is consumed SHALL leave the count unchanged (simultaneous increment and decrement).
- REQ-019: trig=1 with pending count at 2^PEND_W-1 SHALL discard the request and assert drop for one cycle; the count stays saturated.
- REQ-020: A width or gap input change mid-pulse SHALL NOT affect the pulse or gap in progress.

Reset
- REQ-021: rst=1 SHALL immediately force IDLE, pulse_out=0, busy=0, drop=0, counter=0 and pending=0, including mid-pulse.
- REQ-022: The first trig sampled after rst deasserts SHALL be handled as in REQ-012.

Configuration
- REQ-023: Macro PULSE_GEN_PENDING_EN defined SHALL enable the pending counter with the behaviour in REQ-016 to REQ-019.
- REQ-024: Without PULSE_GEN_PENDING_EN, no pending counter SHALL be built; any trig while not IDLE SHALL be discarded with a one-cycle drop, and busy equals state!=IDLE.

Structure
- REQ-025: Package pulse_gen_pkg SHALL hold the state enum (IDLE, HIGH, GAP) and the default CNT_W and PEND_W constants.
- REQ-026: The saturating up/down pending counter SHALL be a sub-module, pulse_gen_pend_cnt, instantiated only under PULSE_GEN_PENDING_EN.

Verification
- REQ-027: width=3, gap=2, one trig at edge 5 -> pulse_out high edges 6-8, low edges 9-10, busy falls at edge 11, drop never asserted.
- REQ-028: width=0, gap=0, one trig -> pulse_out high exactly one cycle.
- REQ-029: Macro on; width=2, gap=1; trig at edges 0, 1, 2 -> three 2-cycle pulses, each separated by exactly 1 low cycle; pending peaks at 2.
- REQ-030: Macro on, PEND_W=2; width=10; 5 trigs during the first pulse -> pending saturates at 3, drop asserted on the 4th and 5th extra trig, 4 pulses total.
- REQ-031: rst asserted on the 2nd cycle of a width=8 pulse -> pulse_out=0 asynchronously, no further pulses, busy=0.
- REQ-032: Macro off; width=4; trig at edges 0 and 2 -> one pulse, drop high for the cycle after edge 2.
